// File: rtl/fifo2r_serial_drain_if.sv
// Bundles the dual-issue FIFO read side and the single-lane output stream of the drain block.
// master = drain block, slave = FIFO/consumer environment.
interface fifo2r_serial_drain_if #(
    parameter int DWIDTH = 32
);
    logic              fifo_empty;
    logic              fifo_1left_to_empty;
    logic [DWIDTH-1:0] rdData0;
    logic [DWIDTH-1:0] rdData1;
    logic              pop0;
    logic              pop1;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] out_data;
    logic [1:0]        occ;

    modport master (
        input  fifo_empty, fifo_1left_to_empty, rdData0, rdData1, flush, out_ready,
        output pop0, pop1, out_valid, out_data, occ
    );

    modport slave (
        output fifo_empty, fifo_1left_to_empty, rdData0, rdData1, flush, out_ready,
        input  pop0, pop1, out_valid, out_data, occ
    );
endinterface

// File: rtl/fifo2r_serial_drain.sv
// Drains a 2-read FIFO into a 2-entry flopped stage and emits one entry/cycle, oldest first.
// Pop in cycle N -> out_data in N+1; out_valid && !out_ready holds data stable, pops stop when stage is full.
module fifo2r_serial_drain #(
    parameter int DWIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fifo2r_serial_drain_if.master bus
);
    logic [1:0]        occ_q, occ_d;
    logic [DWIDTH-1:0] s0_q, s0_d;
    logic [DWIDTH-1:0] s1_q, s1_d;

    logic [1:0] avail;
    logic [1:0] space;
    logic [1:0] npop;
    logic [1:0] surv;
    logic       deq;

    // Pop decision depends only on flags, occupancy and out_ready, never on rdData.
    always_comb begin
        avail = bus.fifo_empty ? 2'd0 : (bus.fifo_1left_to_empty ? 2'd1 : 2'd2);
        deq   = (occ_q != 2'd0) && bus.out_ready;
        space = 2'd2 - occ_q + {1'b0, deq};
        npop  = bus.flush ? 2'd0 : ((avail < space) ? avail : space);
    end

    always_comb begin
        surv  = occ_q - {1'b0, deq};
        s0_d  = deq ? s1_q : s0_q;
        s1_d  = s1_q;
        occ_d = surv + npop;
        if (npop != 2'd0) begin
            if (surv == 2'd0) begin
                s0_d = bus.rdData0;
                if (npop == 2'd2) begin
                    s1_d = bus.rdData1;
                end
            end else begin
                s1_d = bus.rdData0;
            end
        end
        if (bus.flush) begin
            occ_d = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= 2'd0;
            s0_q  <= '0;
            s1_q  <= '0;
        end else begin
            occ_q <= occ_d;
            s0_q  <= s0_d;
            s1_q  <= s1_d;
        end
    end

    assign bus.pop0      = (npop != 2'd0);
    assign bus.pop1      = (npop == 2'd2);
    assign bus.out_valid = (occ_q != 2'd0);
    assign bus.out_data  = s0_q;
    assign bus.occ       = occ_q;

`ifdef ASSERT_ON
    a_pop1_pop0:  assert property (@(posedge clk) disable iff (!rst_n) bus.pop1 |-> bus.pop0);
    a_pop0_avail: assert property (@(posedge clk) disable iff (!rst_n) bus.pop0 |-> !bus.fifo_empty);
    a_pop1_avail: assert property (@(posedge clk) disable iff (!rst_n)
                                   bus.pop1 |-> (!bus.fifo_empty && !bus.fifo_1left_to_empty));
    a_occ_max:    assert property (@(posedge clk) disable iff (!rst_n) occ_q <= 2'd2);
`endif
endmodule
